// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: routes low addresses to the dmem syncram and high addresses
// to a small register bank (TX FIFO, status, free-running cycle counter, scratch).
module dmem_mmio_responder #(
    parameter int unsigned          ADDR_W     = 12,
    parameter int unsigned          DATA_W     = 32,
    parameter logic [ADDR_W-1:0]    MMIO_BASE  = 12'hF00,
    parameter int unsigned          FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_dmem,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q_dmem,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        RegTxData  = 2'd0,
        RegStatus  = 2'd1,
        RegCycles  = 2'd2,
        RegScratch = 2'd3
    } reg_sel_e;

    // Decode
    logic              mmio_hit;
    logic [ADDR_W-1:0] off;
    logic              reg_ok;
    reg_sel_e          reg_sel;

    assign mmio_hit = (address_dmem >= MMIO_BASE);
    assign off      = address_dmem - MMIO_BASE;
    assign reg_ok   = mmio_hit && (off < ADDR_W'(4));
    assign reg_sel  = reg_sel_e'(off[1:0]);

    assign mem_address = address_dmem;
    assign mem_data    = data;
    assign mem_wren    = wren & ~mmio_hit;

    // State
    logic [DATA_W-1:0] fifo_buf [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic [DATA_W-1:0] cycles;
    logic [DATA_W-1:0] scratch;
    logic [DATA_W-1:0] rd_reg;
    logic              rd_mmio;

    logic              full;
    logic              empty;
    logic              reg_wr;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              ovf_set;
    logic              ovf_clr;
    logic              cycles_wr;
    logic              scratch_wr;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] rd_val;
    logic [7:0]        count8;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

    assign tx_valid = ~empty;
    assign tx_data  = fifo_buf[rd_ptr];

    assign reg_wr     = wren & reg_ok;
    assign push_req   = reg_wr && (reg_sel == RegTxData);
    assign pop        = tx_valid & tx_ready;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok    = push_req & (~full | pop);
    assign ovf_set    = push_req & full & ~pop;
    assign ovf_clr    = reg_wr && (reg_sel == RegStatus) && data[2];
    assign cycles_wr  = reg_wr && (reg_sel == RegCycles);
    assign scratch_wr = reg_wr && (reg_sel == RegScratch);

    always_comb begin
        count_d = count;
        unique case ({push_ok, pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    assign count8 = 8'(count);
    assign status = DATA_W'({count8, 5'b0, ovf, full, empty});

    always_comb begin
        rd_val = '0;
        if (reg_ok) begin
            unique case (reg_sel)
                RegTxData:  rd_val = '0;
                RegStatus:  rd_val = status;
                RegCycles:  rd_val = cycles;
                RegScratch: rd_val = scratch;
                default:    rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            cycles  <= '0;
            scratch <= '0;
            rd_reg  <= '0;
            rd_mmio <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_d;
            ovf     <= ovf_set | (ovf & ~ovf_clr);
            cycles  <= cycles_wr ? data : cycles + DATA_W'(1);
            if (scratch_wr) begin
                scratch <= data;
            end
            rd_mmio <= mmio_hit;
            rd_reg  <= rd_val;
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_buf[wr_ptr] <= data;
        end
    end

    assign q_dmem = rd_mmio ? rd_reg : mem_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: read data and TX stream words are checked
// against queues of hand-computed expectations.
module tb_dmem_mmio_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int tests = 0;
    int fails = 0;

    logic [31:0] rd_q [$];
    logic [31:0] tx_q [$];
    logic        rd_issue = 1'b0;
    logic        rd_pend  = 1'b0;
    logic [31:0] dmem [4096];

    dmem_mmio_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .mem_q        (mem_q),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    always #5 clock = ~clock;

    // Syncram model with one cycle of read latency
    always @(posedge clock) begin
        if (mem_wren) dmem[mem_address] <= mem_data;
        mem_q <= dmem[mem_address];
    end

    always @(posedge clock) rd_pend <= rd_issue;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares whenever a read result or a stream handshake is presented
    always @(negedge clock) begin
        if (reset === 1'b1 && rd_pend) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_underflow: got %h, expected no read", q_dmem);
            end else begin
                check("read", q_dmem, rd_q.pop_front());
            end
        end
        if (reset === 1'b1 && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_underflow: got %h, expected no word", tx_data);
            end else begin
                check("tx_data", tx_data, tx_q.pop_front());
            end
        end
    end

    // One bus cycle; signals change 1 time unit after the rising edge
    task automatic cyc(input logic [11:0] a, input logic [31:0] d, input logic we,
                       input logic rd, input logic [31:0] exp, input logic rdy);
        @(posedge clock);
        #1;
        address_dmem = a;
        data         = d;
        wren         = we;
        rd_issue     = rd;
        tx_ready     = rdy;
        if (rd) rd_q.push_back(exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic rdy);
        cyc(a, d, 1'b1, 1'b0, 32'h0, rdy);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic rdy);
        cyc(a, 32'h0, 1'b0, 1'b1, exp, rdy);
    endtask

    task automatic idle(input logic rdy);
        cyc(12'h000, 32'h0, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        address_dmem = 12'h000;
        data         = 32'h0;
        wren         = 1'b0;
        tx_ready     = 1'b0;
        #20;
        check("reset_q_dmem", q_dmem, 32'h0);
        check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        #3;
        // Read CYCLES right across the first edge after release
        address_dmem = 12'hF02;
        rd_issue     = 1'b1;
        rd_q.push_back(32'd0);
        reset        = 1'b1;
        rd(12'hF02, 32'd1, 1'b0);
        rd(12'hF02, 32'd2, 1'b0);

        wr(12'h010, 32'h123, 1'b0);
        #1 check("mem_wren_dmem", {31'b0, mem_wren}, 32'h1);
        rd(12'h010, 32'h123, 1'b0);
        wr(12'hF03, 32'hAA, 1'b0);
        #1 check("mem_wren_mmio", {31'b0, mem_wren}, 32'h0);
        rd(12'hF03, 32'hAA, 1'b0);
        rd(12'hF07, 32'h0, 1'b0);
        rd(12'hF00, 32'h0, 1'b0);

        // Overfill: ninth word dropped, ovf set
        for (int i = 1; i <= 9; i++) begin
            wr(12'hF00, 32'(i), 1'b0);
            if (i <= 8) tx_q.push_back(32'(i));
        end
        rd(12'hF01, 32'h0806, 1'b0);
        #1 check("head_hold", tx_data, 32'h1);
        check("valid_hold", {31'b0, tx_valid}, 32'h1);
        for (int i = 0; i < 8; i++) idle(1'b1);
        rd(12'hF01, 32'h0005, 1'b1);
        wr(12'hF01, 32'h4, 1'b1);
        rd(12'hF01, 32'h0001, 1'b1);

        // Push into a full FIFO on the same edge as a pop
        for (int i = 0; i < 8; i++) begin
            wr(12'hF00, 32'h11 + 32'(i), 1'b0);
            tx_q.push_back(32'h11 + 32'(i));
        end
        wr(12'hF00, 32'h55, 1'b1);
        tx_q.push_back(32'h55);
        rd(12'hF01, 32'h0802, 1'b0);
        for (int i = 0; i < 8; i++) idle(1'b1);
        rd(12'hF01, 32'h0001, 1'b1);

        // Counter wrap
        wr(12'hF02, 32'hFFFF_FFFE, 1'b0);
        idle(1'b0);
        rd(12'hF02, 32'hFFFF_FFFF, 1'b0);
        rd(12'hF02, 32'h0000_0000, 1'b0);

        // Reset mid-drain
        for (int i = 0; i < 5; i++) begin
            wr(12'hF00, 32'h21 + 32'(i), 1'b0);
            tx_q.push_back(32'h21 + 32'(i));
        end
        idle(1'b1);
        idle(1'b1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_q_dmem", q_dmem, 32'h0);
        check("rst_flushed", 32'(tx_q.size()), 32'd3);
        tx_q.delete();
        @(negedge clock);
        #2;
        reset    = 1'b1;
        tx_ready = 1'b0;
        rd(12'hF01, 32'h0001, 1'b0);
        rd(12'hF03, 32'h0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        @(negedge clock);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("tx_q_drained", 32'(tx_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
